// File: rtl/tapped_shift_window.sv
// Tapped shift window: DEPTH-stage sample delay line exposing every stage,
// per-stage valid flags, a saturating fill count and an end-of-line strobe.
module tapped_shift_window #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       inp,
  output logic [WIDTH*DEPTH-1:0] taps,
  output logic [DEPTH-1:0]       tap_valid,
  output logic [WIDTH-1:0]       outp,
  output logic                   out_valid,
  output logic [CW-1:0]          count,
  output logic                   window_full
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [DEPTH-1:0] tap_valid_q, tap_valid_d;
  logic [CW-1:0]    count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic             feed_valid;

  // Validity of the word that lands in the last stage on a shift.
  generate
    if (DEPTH == 1) begin : g_feed_single
      assign feed_valid = 1'b1;
    end else begin : g_feed_multi
      assign feed_valid = tap_valid_q[DEPTH-2];
    end
  endgenerate

  always_comb begin
    stage_d     = stage_q;
    tap_valid_d = tap_valid_q;
    count_d     = count_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      stage_d[0]     = inp;
      tap_valid_d[0] = 1'b1;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i]     = stage_q[i-1];
        tap_valid_d[i] = tap_valid_q[i-1];
      end
      if (count_q != CW'(DEPTH)) begin
        count_d = count_q + CW'(1);
      end
      out_valid_d = feed_valid;
    end
  end

  // Reset and flush clear identically; reset simply wins if both are high.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
      tap_valid_q <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
      tap_valid_q <= tap_valid_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
    end
  end

  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_taps
      assign taps[(DEPTH-1-g)*WIDTH +: WIDTH] = stage_q[g];
    end
  endgenerate

  assign tap_valid   = tap_valid_q;
  assign outp        = stage_q[DEPTH-1];
  assign out_valid   = out_valid_q;
  assign count       = count_q;
  assign window_full = (count_q == CW'(DEPTH));

endmodule

// File: doc/tapped_shift_window.md
TAPPED_SHIFT_WINDOW -- requirements
Module: tapped_shift_window

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning bits per sample word (WIDTH >= 1).
REQ-002 The module SHALL have parameter DEPTH, default 4, meaning number of register stages and taps (DEPTH >= 1).
REQ-003 The module SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The module SHALL have port flush  input  1  synchronous clear of window contents.
REQ-006 The module SHALL have port in_valid  input  1  sample present; the window advances only when high.
REQ-007 The module SHALL have port inp  input  WIDTH  sample word.
REQ-008 The module SHALL have port taps  output  WIDTH*DEPTH  all stage contents; most significant word = stage 0 (newest), least significant word = stage DEPTH-1 (oldest).
REQ-009 The module SHALL have port tap_valid  output  DEPTH  per-stage valid flags; bit i corresponds to stage i.
REQ-010 The module SHALL have port outp  output  WIDTH  contents of stage DEPTH-1.
REQ-011 The module SHALL have port out_valid  output  1  one-cycle pulse: a valid word just reached stage DEPTH-1 through a shift.
REQ-012 The module SHALL have port count  output  $clog2(DEPTH+1)  number of valid stages, saturating at DEPTH.
REQ-013 The module SHALL have port window_full  output  1  high when count == DEPTH.

Function
REQ-014 When in_valid=1 and flush=0, the module SHALL load stage 0 with inp and stage i with stage i-1 for i = 1..DEPTH-1, with tap_valid shifting alongside and tap_valid[0] set to 1.
REQ-015 When in_valid=0 and flush=0, all stages, tap_valid and count SHALL hold their values.
REQ-016 The latency from a sample accepted at edge N to that sample appearing on stage k SHALL be k+1 accepted samples; there SHALL be no advance on idle cycles.
REQ-017 On each accepted sample, count SHALL increment by 1 while count < DEPTH and SHALL hold at DEPTH otherwise, so that it never wraps.
REQ-018 window_full SHALL be combinational from count.
REQ-019 count SHALL always equal the popcount of tap_valid, and tap_valid SHALL always be a contiguous run of ones starting at bit 0.
REQ-020 out_valid SHALL be registered and set for exactly one cycle after an edge where a shift occurred and stage DEPTH-2 (or inp, when DEPTH=1) was valid; it SHALL otherwise be 0.
REQ-021 When flush=1, the next edge SHALL zero all stage data, tap_valid, count and out_valid.
REQ-022 flush SHALL take priority over in_valid in the same cycle, and the sample presented with flush SHALL be discarded.
REQ-023 The first accepted sample after a flush SHALL restart fill from count=0, giving count=1 and tap_valid=...0001.
REQ-024 For DEPTH=1, taps SHALL equal outp, window_full SHALL follow tap_valid[0], and out_valid SHALL pulse on every accepted sample.
REQ-025 inp SHALL be sampled only on accepted cycles, and X on inp while in_valid=0 SHALL NOT propagate into state.

Reset
REQ-026 While rst=1 at a clock edge, all stages SHALL become 0 and tap_valid, count, out_valid and window_full SHALL become 0.
REQ-027 rst SHALL take priority over flush and in_valid.
REQ-028 Reset asserted mid-fill SHALL discard all contents, and the first accepted sample after deassertion SHALL behave as after a flush.
REQ-029 No output SHALL depend combinationally on inp, in_valid, flush or rst.

Verification
REQ-030 The bench SHALL cover this fill: WIDTH=8, DEPTH=4, rst, then in_valid on 4 consecutive cycles with inp=0x11,0x22,0x33,0x44 -> taps=0x44332211, tap_valid=4'b1111, count=4, window_full=1, out_valid pulses once, the cycle after 0x11 enters stage 3.
REQ-031 The bench SHALL cover stall: same fill with in_valid low for 3 cycles between samples 2 and 3 -> taps and count hold during the gap, and the final state is identical to REQ-030.
REQ-032 The bench SHALL cover saturation: 6 accepted samples 0x01..0x06 -> taps=0x06050403, count stays 4, and out_valid pulses on each of samples 4, 5 and 6.
REQ-033 The bench SHALL cover flush collision: full window, then flush=1 with in_valid=1 and inp=0xAA -> next cycle taps=0, count=0, tap_valid=0, and 0xAA is absent; one more sample 0xBB -> taps=0xBB000000, count=1.
REQ-034 The bench SHALL cover reset mid-fill: 2 samples accepted, then rst=1 together with in_valid=1 and flush=0 -> all outputs 0 on the next cycle.
REQ-035 The bench SHALL cover DEPTH=1: samples 0x5A,0xA5 -> outp follows each after one accepted edge, with out_valid high each time.
